// File: rtl/eim_bus_frontend.sv
// i.MX EIM multiplexed address/data bus front end: synchronizes the raw pins,
// decodes address/read/write phases and talks to the downstream register bank.
module eim_bus_frontend #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int RD_TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              eim_cs0_n,
   input  logic              eim_lba_n,
   input  logic              eim_wr_n,
   input  logic              eim_oe_n,
   input  logic [DATA_W-1:0] da_in,
   output logic [DATA_W-1:0] da_out,
   output logic              da_oe,
   output logic              eim_wait_n,
   output logic              wr_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_valid,
   input  logic [DATA_W-1:0] rd_data,
   output logic              rd_timeout
);

   localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, ADDR, RD_WAIT, RD_HOLD, WR_WAIT} state_t;

   // Control bits packed as {cs, lba, wr, oe}; all idle high.
   logic [SYNC_STAGES-1:0][3:0]        ctl_sync_q, ctl_sync_d;
   logic [SYNC_STAGES-1:0][DATA_W-1:0] da_sync_q, da_sync_d;
   logic [1:0]                         hist_q, hist_d;

   logic              cs_s, lba_s, wr_s, oe_s;
   logic [DATA_W-1:0] da_s;
   logic              lba_fall, lba_rise, wr_fall, wr_rise;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] da_out_q, da_out_d;
   logic              da_oe_q, da_oe_d;
   logic              wait_n_q, wait_n_d;
   logic              wr_valid_q, wr_valid_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              rd_req_q, rd_req_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              rd_timeout_q, rd_timeout_d;

   always_comb begin
      ctl_sync_d = {ctl_sync_q[SYNC_STAGES-2:0], {eim_cs0_n, eim_lba_n, eim_wr_n, eim_oe_n}};
      da_sync_d  = {da_sync_q[SYNC_STAGES-2:0], da_in};
   end

   assign cs_s  = ctl_sync_q[SYNC_STAGES-1][3];
   assign lba_s = ctl_sync_q[SYNC_STAGES-1][2];
   assign wr_s  = ctl_sync_q[SYNC_STAGES-1][1];
   assign oe_s  = ctl_sync_q[SYNC_STAGES-1][0];
   assign da_s  = da_sync_q[SYNC_STAGES-1];

   assign hist_d   = {lba_s, wr_s};
   assign lba_fall =  hist_q[1] & ~lba_s;
   assign lba_rise = ~hist_q[1] &  lba_s;
   assign wr_fall  =  hist_q[0] & ~wr_s;
   assign wr_rise  = ~hist_q[0] &  wr_s;

   always_comb begin
      // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
      state_d      = state_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      da_out_d     = da_out_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      rd_addr_d    = rd_addr_q;
      wr_valid_d   = 1'b0;
      rd_req_d     = 1'b0;
      rd_timeout_d = 1'b0;

      case (state_q)
         IDLE: if (lba_fall && !cs_s) begin
            addr_d  = da_s[ADDR_W-1:0];
            state_d = ADDR;
         end
         ADDR: if (lba_rise) begin
            if (!wr_s) begin
               state_d = WR_WAIT;
            end else begin
               rd_req_d  = 1'b1;
               rd_addr_d = addr_q;
               cnt_d     = '0;
               state_d   = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (wr_fall) begin
               state_d = WR_WAIT;
            end else if (rd_valid) begin
               da_out_d = rd_data;
               state_d  = RD_HOLD;
            end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
               da_out_d     = '1;
               rd_timeout_d = 1'b1;
               state_d      = RD_HOLD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RD_HOLD: begin
            if (lba_fall) begin
               addr_d  = da_s[ADDR_W-1:0];
               state_d = ADDR;
            end else if (wr_fall) begin
               state_d = WR_WAIT;
            end
         end
         WR_WAIT: if (wr_rise) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = da_s;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Chip-select deassertion abandons whatever transfer is in flight.
      if (state_q != IDLE && cs_s) begin
         state_d      = IDLE;
         addr_d       = addr_q;
         da_out_d     = da_out_q;
         wr_addr_d    = wr_addr_q;
         wr_data_d    = wr_data_q;
         rd_addr_d    = rd_addr_q;
         wr_valid_d   = 1'b0;
         rd_req_d     = 1'b0;
         rd_timeout_d = 1'b0;
      end

      da_oe_d  = (state_d == RD_HOLD) && !oe_s;
      wait_n_d = !((state_d == RD_WAIT) && !oe_s);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctl_sync_q   <= '1;
         da_sync_q    <= '0;
         hist_q       <= '1;
         state_q      <= IDLE;
         addr_q       <= '0;
         cnt_q        <= '0;
         da_out_q     <= '0;
         da_oe_q      <= 1'b0;
         wait_n_q     <= 1'b1;
         wr_valid_q   <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         rd_req_q     <= 1'b0;
         rd_addr_q    <= '0;
         rd_timeout_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         ctl_sync_q   <= ctl_sync_d;
         da_sync_q    <= da_sync_d;
         hist_q       <= hist_d;
         state_q      <= state_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         da_out_q     <= da_out_d;
         da_oe_q      <= da_oe_d;
         wait_n_q     <= wait_n_d;
         wr_valid_q   <= wr_valid_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         rd_req_q     <= rd_req_d;
         rd_addr_q    <= rd_addr_d;
         rd_timeout_q <= rd_timeout_d;
      end
   end

   assign da_out     = da_out_q;
   assign da_oe      = da_oe_q;
   assign eim_wait_n = wait_n_q;
   assign wr_valid   = wr_valid_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign rd_req     = rd_req_q;
   assign rd_addr    = rd_addr_q;
   assign rd_timeout = rd_timeout_q;

endmodule
